// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers,
// with optional burst lock per grant and a watchdog on the transmitter's done tick.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DBIT        = 8,
    parameter int MAX_BURST   = 4,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic                 tx_start,
    output logic [DBIT-1:0]      t_data,
    input  logic                 tx_done,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 timeout,
    output logic [1:0]           dbg_state_o
);

    localparam int LW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST   = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [3:0]     BURST_MAX = 4'(MAX_BURST);

    // Handshake: a byte is taken from requester i on the edge that raises req_ack[i];
    // the requester must hold req_data slice i stable while req_valid[i] is high until then.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic            tx_start_q, tx_start_d;
    logic [DBIT-1:0] t_data_q, t_data_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [LW-1:0]   last_q, last_d;
    logic [LW-1:0]   owner_q, owner_d;
    logic [3:0]      burst_q, burst_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [LW-1:0]   scan_idx;
    logic [DBIT-1:0] win_data;
    logic [DBIT-1:0] own_data;

    // Scan starts just after the previous owner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = LW'((int'(last_q) + k) % NREQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (LW'(i) == win_idx) win_data = req_data[i*DBIT +: DBIT];
            if (LW'(i) == owner_q) own_data = req_data[i*DBIT +: DBIT];
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ack_d  = '0;
        tx_start_d = 1'b0;
        t_data_d   = t_data_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        last_d     = last_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    t_data_d          = win_data;
                    grant_d           = '0;
                    grant_d[win_idx]  = 1'b1;
                    req_ack_d[win_idx] = 1'b1;
                    tx_start_d        = 1'b1;
                    owner_d           = win_idx;
                    burst_d           = 4'd1;
                    state_d           = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wdog_q != {WDW{1'b1}}) wdog_d = wdog_q + 1'b1;
                if (tx_done) begin
                    if (req_valid[owner_q] && (burst_q < BURST_MAX)) begin
                        t_data_d           = own_data;
                        req_ack_d[owner_q] = 1'b1;
                        tx_start_d         = 1'b1;
                        burst_d            = burst_q + 4'd1;
                        state_d            = S_START;
                    end else begin
                        last_d  = owner_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end else if ((TIMEOUT_CYC != 0) && (wdog_q == WD_LAST)) begin
                    // The byte in flight is dropped; the owner must re-request.
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    grant_d   = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            t_data_q   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= LW'(NREQ - 1);
            owner_q    <= '0;
            burst_q    <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            t_data_q   <= t_data_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            wdog_q     <= wdog_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign t_data      = t_data_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producers and a UART responder drive the DUT; a transaction-level
// round-robin/burst model fills the expected queue and a monitor checks every tx_start.
module tb_uart_tx_arbiter;

    localparam int NREQ        = 4;
    localparam int DBIT        = 8;
    localparam int MAX_BURST   = 3;
    localparam int TIMEOUT_CYC = 120;
    localparam int W           = 12;   // {latency[1:0], requester[1:0], byte[7:0]}

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_ack;
    logic                 tx_start;
    logic [DBIT-1:0]      t_data;
    logic                 tx_done;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 timeout;
    logic [1:0]           dbg_state;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_start(tx_start), .t_data(t_data), .tx_done(tx_done),
        .grant(grant), .busy(busy), .timeout(timeout), .dbg_state_o(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0]    exp_q[$];
    int              delay_q[$];
    logic [DBIT-1:0] prod_q[NREQ][$];
    int              exp_to = 0;
    int              seen_to = 0;
    int              m_last = NREQ - 1;
    int              ph_cnt[NREQ];
    logic [DBIT-1:0] ph_data[NREQ][8];
    int              stray_cnt = 0;
    int              stray_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 0;                 // never answer: watchdog path
        if (r == 1) return TIMEOUT_CYC;       // done lands on the expiry cycle
        return int'($urandom_range(1, 20));
    endfunction

    // Reference model: serve requesters round-robin from the last owner, up to MAX_BURST
    // bytes each while they still have data; a dropped byte ends the burst.
    task automatic load_phase(input int fixed_delay);
        int rem[NREQ];
        int pos[NREQ];
        int lat, w, n, d;
        bit cont, any;
        lat = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = ph_cnt[i];
            pos[i] = 0;
            for (int j = 0; j < ph_cnt[i]; j++) prod_q[i].push_back(ph_data[i][j]);
        end
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) any = 1'b1;
        while (any) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && rem[(m_last + k) % NREQ] > 0) w = (m_last + k) % NREQ;
            n = 0;
            cont = 1'b1;
            while (cont) begin
                d = (fixed_delay >= 0) ? fixed_delay : pick_delay();
                exp_q.push_back({2'(lat), 2'(w), ph_data[w][pos[w]]});
                delay_q.push_back(d);
                if (d == 0) exp_to++;
                pos[w]++;
                rem[w]--;
                n++;
                cont = (d != 0) && (rem[w] > 0) && (n < MAX_BURST);
                lat  = (d == 0 || cont) ? 1 : 2;
            end
            m_last = w;
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (rem[i] > 0) any = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int  t;
        bit  ok;
        bit  empty;
        t  = 0;
        ok = 1'b0;
        while (t < 6000 && !ok) begin
            @(negedge clk);
            #1;
            t++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (prod_q[i].size() != 0) empty = 1'b0;
            ok = empty && (exp_q.size() == 0) && (delay_q.size() == 0) && !busy;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_drain: got pending=%0d expected pending=0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
        #1;
        check({name, "_grant_idle"}, grant, 0);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_timeouts"}, seen_to, exp_to);
    endtask

    // Producers: present the head of each queue, drop it once acked.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
                if (prod_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DBIT +: DBIT] = prod_q[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // UART responder: answers each tx_start with tx_done after the planned delay.
    initial begin
        int d;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_done) begin
                @(posedge clk); #1 tx_done = 1'b1;
                @(posedge clk); #1 tx_done = 1'b0;
                stray_done++;
            end else if (reset && tx_start && delay_q.size() > 0) begin
                d = delay_q.pop_front();
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1 tx_done = 1'b1;
                    @(posedge clk);
                    #1 tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor.
    initial begin
        int              cyc, ev_cyc, st_cyc;
        logic [W-1:0]    e;
        logic [DBIT-1:0] cur_byte;
        cyc = 0; ev_cyc = 0; st_cyc = 0; cur_byte = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("busy_vs_grant", busy, |grant);
                check("ack_with_start", |req_ack, tx_start);
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_start: got grant=%0h expected no transfer", grant);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant", grant, 32'd1 << e[9:8]);
                        check("req_ack", req_ack, 32'd1 << e[9:8]);
                        check("t_data", t_data, e[7:0]);
                        if (e[11:10] != 2'd0) check("start_latency", cyc - ev_cyc, e[11:10]);
                        cur_byte = e[7:0];
                        st_cyc   = cyc;
                    end
                end
                if (tx_done && busy) begin
                    check("t_data_held", t_data, cur_byte);
                    ev_cyc = cyc;
                end
                if (timeout) begin
                    seen_to++;
                    check("timeout_delay", cyc - st_cyc, TIMEOUT_CYC + 1);
                    ev_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ack", req_ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_t_data", t_data, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;

        // Single byte from requester 0, done after 100 cycles.
        for (int i = 0; i < NREQ; i++) ph_cnt[i] = 0;
        ph_cnt[0] = 1;
        ph_data[0][0] = 8'hA5;
        load_phase(100);
        wait_idle("single");
        check("t_data_after_done", t_data, 8'hA5);

        // Everyone valid, two bytes each.
        for (int i = 0; i < NREQ; i++) begin
            ph_cnt[i] = 2;
            for (int j = 0; j < 8; j++) ph_data[i][j] = 8'($urandom());
        end
        load_phase(-1);
        wait_idle("all_valid");

        // Two requesters whose bytes are never acknowledged by the UART.
        for (int i = 0; i < NREQ; i++) ph_cnt[i] = 0;
        ph_cnt[1] = 1;
        ph_cnt[3] = 1;
        ph_data[1][0] = 8'h11;
        ph_data[3][0] = 8'h33;
        load_phase(0);
        wait_idle("watchdog");

        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < NREQ; i++) begin
                ph_cnt[i] = ($urandom_range(0, 2) != 0) ? int'($urandom_range(1, 5)) : 0;
                for (int j = 0; j < 8; j++) ph_data[i][j] = 8'($urandom());
            end
            load_phase(-1);
            wait_idle("random");
        end

        // Reset while waiting for done.
        for (int i = 0; i < NREQ; i++) ph_cnt[i] = 0;
        ph_cnt[2] = 1;
        ph_data[2][0] = 8'h3C;
        load_phase(0);
        exp_to--;
        t = 0;
        while (!busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reset_test_busy", busy, 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_req_ack", req_ack, 0);
        check("arst_tx_start", tx_start, 0);
        check("arst_t_data", t_data, 0);
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_timeout", timeout, 0);
        m_last = NREQ - 1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        stray_cnt++;
        repeat (6) @(negedge clk);
        #1;
        check("stray_done_busy", busy, 0);
        check("stray_done_grant", grant, 0);

        // After reset requester 0 has first priority.
        for (int i = 0; i < NREQ; i++) begin
            ph_cnt[i] = int'($urandom_range(1, 3));
            for (int j = 0; j < 8; j++) ph_data[i][j] = 8'($urandom());
        end
        load_phase(-1);
        wait_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
